// File: rtl/decode_ctrl_pipe_if.sv
// decode_ctrl_pipe_if: handshake, instruction and decoded-control bundle between fetch, decoder and execute
// master: fetch/execute side (drives in_valid, instr, flush, out_ready)
// slave : decoder side (drives in_ready, out_valid, ctrl_*, stall_cycles)
interface decode_ctrl_pipe_if #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            instr;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [2:0]             ctrl_aluop;
    logic                   ctrl_regwrite;
    logic [REG_ADDR_W-1:0]  ctrl_dest;
    logic [1:0]             ctrl_jump;
    logic [1:0]             ctrl_branch;
    logic [1:0]             ctrl_mem_rw;
    logic                   ctrl_byte;
    logic                   ctrl_load;
    logic                   ctrl_store;
    logic                   ctrl_illegal;
    logic [STALL_CNT_W-1:0] stall_cycles;
    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, ctrl_aluop, ctrl_regwrite, ctrl_dest, ctrl_jump, ctrl_branch,
               ctrl_mem_rw, ctrl_byte, ctrl_load, ctrl_store, ctrl_illegal, stall_cycles
    );
    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, ctrl_aluop, ctrl_regwrite, ctrl_dest, ctrl_jump, ctrl_branch,
               ctrl_mem_rw, ctrl_byte, ctrl_load, ctrl_store, ctrl_illegal, stall_cycles
    );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: registered control decoder with load-use hazard scoreboard and flush
// clk, rst    : clock, asynchronous active-high reset
// bus (slave) : in_valid/in_ready/instr/flush from fetch, out_valid/out_ready and ctrl_* to execute,
//               stall_cycles saturating count of hazard-stall cycles
module decode_ctrl_pipe #(
    parameter int REG_ADDR_W  = 5,
    parameter int LOAD_LAT    = 2,
    parameter int STALL_CNT_W = 16
) (
    input logic clk,
    input logic rst,
    decode_ctrl_pipe_if.slave bus
);
    localparam int NREG = 1 << REG_ADDR_W;
    logic [5:0]             op, fn;
    logic [REG_ADDR_W-1:0]  rs, rt, rd;
    logic [2:0]             d_aluop;
    logic                   d_regwrite;
    logic [REG_ADDR_W-1:0]  d_dest;
    logic [1:0]             d_jump, d_branch, d_mem_rw;
    logic                   d_byte, d_load, d_store, d_illegal;
    logic [2:0]             d_use;
    logic                   full, hazard, issue, accept;
    logic [2:0]             q_use;
    logic [REG_ADDR_W-1:0]  q_rs, q_rt, q_rd;
    logic [2:0]             q_aluop;
    logic                   q_regwrite;
    logic [REG_ADDR_W-1:0]  q_dest;
    logic [1:0]             q_jump, q_branch, q_mem_rw;
    logic                   q_byte, q_load, q_store, q_illegal;
    logic [STALL_CNT_W-1:0] stall;
    logic [2:0]             cnt [NREG];
    assign op = bus.instr[31:26];
    assign fn = bus.instr[5:0];
    assign rs = REG_ADDR_W'(bus.instr[25:21]);
    assign rt = REG_ADDR_W'(bus.instr[20:16]);
    assign rd = REG_ADDR_W'(bus.instr[15:11]);
    // d_use flags which of rs/rt/rd the instruction reads, checked later against the scoreboard
    always_comb begin
        d_aluop    = 3'd0;
        d_regwrite = 1'b0;
        d_dest     = '0;
        d_jump     = 2'b11;
        d_branch   = 2'b00;
        d_mem_rw   = 2'b00;
        d_byte     = 1'b0;
        d_load     = 1'b0;
        d_store    = 1'b0;
        d_illegal  = 1'b0;
        d_use      = 3'b000;
        case (op)
            6'h03:
                case (fn)
                    6'h08: begin d_jump = 2'b10; d_use = 3'b100; end
                    6'h21: begin d_regwrite = 1'b1; d_dest = rt; d_mem_rw = 2'b10; d_load = 1'b1; d_use = 3'b101; end
                    6'h13: begin d_mem_rw = 2'b01; d_store = 1'b1; d_use = 3'b111; end
                    default: begin d_regwrite = 1'b1; d_dest = rd; d_use = 3'b110; end
                endcase
            6'h02: d_jump = 2'b01;
            6'h07: begin d_jump = 2'b01; d_regwrite = 1'b1; d_dest = REG_ADDR_W'(31); d_aluop = 3'd1; end
            6'h09: begin d_aluop = 3'd1; d_regwrite = 1'b1; d_dest = rt; d_use = 3'b100; end
            6'h0c: begin d_aluop = 3'd3; d_regwrite = 1'b1; d_dest = rt; d_use = 3'b100; end
            6'h0e: begin d_aluop = 3'd4; d_regwrite = 1'b1; d_dest = rt; d_use = 3'b100; end
            6'h0f: begin d_regwrite = 1'b1; d_dest = rt; end
            6'h05: begin d_jump = 2'b00; d_branch = 2'b01; d_aluop = 3'd2; d_use = 3'b110; end
            6'h04: begin d_jump = 2'b00; d_branch = 2'b10; d_aluop = 3'd2; d_use = 3'b110; end
            6'h22: begin d_regwrite = 1'b1; d_dest = rt; d_mem_rw = 2'b10; d_load = 1'b1; d_byte = 1'b1; d_use = 3'b100; end
            6'h12: begin d_regwrite = 1'b1; d_dest = rt; d_mem_rw = 2'b10; d_load = 1'b1; d_use = 3'b100; end
            6'h28: begin d_mem_rw = 2'b01; d_store = 1'b1; d_byte = 1'b1; d_use = 3'b110; end
            6'h2b: begin d_mem_rw = 2'b01; d_store = 1'b1; d_use = 3'b110; end
            default: d_illegal = 1'b1;
        endcase
    end
    assign hazard = full && ((q_use[2] && q_rs != '0 && cnt[q_rs] != '0) ||
                             (q_use[1] && q_rt != '0 && cnt[q_rt] != '0) ||
                             (q_use[0] && q_rd != '0 && cnt[q_rd] != '0));
    assign bus.out_valid = full && !hazard && !bus.flush;
    assign issue         = bus.out_valid && bus.out_ready;
    assign bus.in_ready  = !bus.flush && (!full || issue);
    assign accept        = bus.in_valid && bus.in_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full       <= 1'b0;
            q_use      <= '0;
            q_rs       <= '0;
            q_rt       <= '0;
            q_rd       <= '0;
            q_aluop    <= '0;
            q_regwrite <= 1'b0;
            q_dest     <= '0;
            q_jump     <= '0;
            q_branch   <= '0;
            q_mem_rw   <= '0;
            q_byte     <= 1'b0;
            q_load     <= 1'b0;
            q_store    <= 1'b0;
            q_illegal  <= 1'b0;
            stall      <= '0;
        end else begin
            full <= !bus.flush && (accept || (full && !issue));
            if (accept) begin
                q_use      <= d_use;
                q_rs       <= rs;
                q_rt       <= rt;
                q_rd       <= rd;
                q_aluop    <= d_aluop;
                q_regwrite <= d_regwrite;
                q_dest     <= d_dest;
                q_jump     <= d_jump;
                q_branch   <= d_branch;
                q_mem_rw   <= d_mem_rw;
                q_byte     <= d_byte;
                q_load     <= d_load;
                q_store    <= d_store;
                q_illegal  <= d_illegal;
            end
            if (hazard && !bus.flush && !(&stall))
                stall <= stall + STALL_CNT_W'(1);
        end
    end
    // A load issuing this cycle reloads its entry; that reload takes priority over the countdown
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
        else
            for (int i = 0; i < NREG; i++)
                cnt[i] <= (issue && q_load && i != 0 && q_dest == REG_ADDR_W'(i)) ? 3'(LOAD_LAT)
                                                                               : cnt[i] - 3'(cnt[i] != '0);
    end
    assign bus.ctrl_aluop    = q_aluop;
    assign bus.ctrl_regwrite = q_regwrite;
    assign bus.ctrl_dest     = q_dest;
    assign bus.ctrl_jump     = q_jump;
    assign bus.ctrl_branch   = q_branch;
    assign bus.ctrl_mem_rw   = q_mem_rw;
    assign bus.ctrl_byte     = q_byte;
    assign bus.ctrl_load     = q_load;
    assign bus.ctrl_store    = q_store;
    assign bus.ctrl_illegal  = q_illegal;
    assign bus.stall_cycles  = stall;
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe: directed and random checks of decode_ctrl_pipe against a scoreboard/decode reference
module tb_decode_ctrl_pipe;
    typedef enum {K_ALU, K_JR, K_LWN, K_SWN, K_J, K_JAL, K_ADDI, K_ANDI, K_ORI, K_LUI,
                  K_BEQ, K_BNE, K_LBU, K_LW, K_SB, K_SW, K_ILL} kind_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] instr = '0;
    int          tests = 0, fails = 0, cyc = 0;
    int          lat [2] = '{2, 1};
    bit          m_full [2];
    logic [31:0] m_instr [2];
    int          m_stall [2];
    int          avail [2][32];
    logic [4:0]  dq [$];
    logic [18:0] dut_b [2];
    logic        ov_o [2], ir_o [2];
    logic [15:0] st_o [2];
    bit          acc;
    int          idx;

    decode_ctrl_pipe_if #(.REG_ADDR_W(5), .STALL_CNT_W(16)) bus0 ();
    decode_ctrl_pipe_if #(.REG_ADDR_W(5), .STALL_CNT_W(16)) bus1 ();
    assign bus0.in_valid = in_valid;
    assign bus0.instr = instr;
    assign bus0.flush = flush;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid = in_valid;
    assign bus1.instr = instr;
    assign bus1.flush = flush;
    assign bus1.out_ready = out_ready;
    decode_ctrl_pipe #(.REG_ADDR_W(5), .LOAD_LAT(2), .STALL_CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    decode_ctrl_pipe #(.REG_ADDR_W(5), .LOAD_LAT(1), .STALL_CNT_W(16)) u1 (.clk(clk), .rst(rst), .bus(bus1));
    assign dut_b[0] = {bus0.ctrl_aluop, bus0.ctrl_regwrite, bus0.ctrl_dest, bus0.ctrl_jump, bus0.ctrl_branch,
                       bus0.ctrl_mem_rw, bus0.ctrl_byte, bus0.ctrl_load, bus0.ctrl_store, bus0.ctrl_illegal};
    assign dut_b[1] = {bus1.ctrl_aluop, bus1.ctrl_regwrite, bus1.ctrl_dest, bus1.ctrl_jump, bus1.ctrl_branch,
                       bus1.ctrl_mem_rw, bus1.ctrl_byte, bus1.ctrl_load, bus1.ctrl_store, bus1.ctrl_illegal};
    assign ov_o[0] = bus0.out_valid;
    assign ov_o[1] = bus1.out_valid;
    assign ir_o[0] = bus0.in_ready;
    assign ir_o[1] = bus1.in_ready;
    assign st_o[0] = bus0.stall_cycles;
    assign st_o[1] = bus1.stall_cycles;

    always #5 clk = ~clk;

    function automatic kind_t kind_of(input logic [31:0] i);
        case (i[31:26])
            6'h03: return i[5:0] == 6'h08 ? K_JR : i[5:0] == 6'h21 ? K_LWN : i[5:0] == 6'h13 ? K_SWN : K_ALU;
            6'h02: return K_J;
            6'h07: return K_JAL;
            6'h09: return K_ADDI;
            6'h0c: return K_ANDI;
            6'h0e: return K_ORI;
            6'h0f: return K_LUI;
            6'h05: return K_BEQ;
            6'h04: return K_BNE;
            6'h22: return K_LBU;
            6'h12: return K_LW;
            6'h28: return K_SB;
            6'h2b: return K_SW;
            default: return K_ILL;
        endcase
    endfunction

    // Bundle layout: {aluop, regwrite, dest, jump, branch, mem_rw, byte, load, store, illegal}
    function automatic logic [18:0] ref_bundle(input logic [31:0] i);
        kind_t c;
        logic [2:0] alu;
        logic wr;
        logic [4:0] dst;
        logic [1:0] jmp, br, mem;
        c = kind_of(i);
        alu = (c inside {K_JAL, K_ADDI}) ? 3'd1 : c == K_ANDI ? 3'd3 : c == K_ORI ? 3'd4 :
              (c inside {K_BEQ, K_BNE}) ? 3'd2 : 3'd0;
        wr = c inside {K_ALU, K_JAL, K_ADDI, K_ANDI, K_ORI, K_LUI, K_LW, K_LBU, K_LWN};
        dst = !wr ? 5'd0 : c == K_ALU ? i[15:11] : c == K_JAL ? 5'd31 : i[20:16];
        jmp = (c inside {K_J, K_JAL}) ? 2'b01 : c == K_JR ? 2'b10 : (c inside {K_BEQ, K_BNE}) ? 2'b00 : 2'b11;
        br = c == K_BEQ ? 2'b01 : c == K_BNE ? 2'b10 : 2'b00;
        mem = (c inside {K_LW, K_LBU, K_LWN}) ? 2'b10 : (c inside {K_SW, K_SB, K_SWN}) ? 2'b01 : 2'b00;
        return {alu, wr, dst, jmp, br, mem, (c inside {K_LBU, K_SB}), mem == 2'b10, mem == 2'b01, c == K_ILL};
    endfunction

    function automatic bit busy(input int k, input logic [4:0] r);
        return r != 5'd0 && cyc < avail[k][r];
    endfunction

    function automatic bit ref_hazard(input int k, input logic [31:0] i);
        kind_t c;
        bit urs, urt, urd;
        c = kind_of(i);
        urs = !(c inside {K_J, K_JAL, K_LUI, K_ILL});
        urt = c inside {K_ALU, K_BEQ, K_BNE, K_SB, K_SW, K_SWN};
        urd = c inside {K_LWN, K_SWN};
        return (urs && busy(k, i[25:21])) || (urt && busy(k, i[20:16])) || (urd && busy(k, i[15:11]));
    endfunction

    function automatic logic [31:0] r_type(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [5:0] f);
        return {6'h03, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
        return {o, s, t, imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] o, f;
        f = 6'($urandom);
        case ($urandom_range(0, 17))
            0: begin o = 6'h03; f = 6'h20; end
            1: begin o = 6'h03; f = 6'h08; end
            2: begin o = 6'h03; f = 6'h21; end
            3: begin o = 6'h03; f = 6'h13; end
            4: o = 6'h02;
            5: o = 6'h07;
            6: o = 6'h09;
            7: o = 6'h0c;
            8: o = 6'h0e;
            9: o = 6'h0f;
            10: o = 6'h05;
            11: o = 6'h04;
            12: o = 6'h22;
            13: o = 6'h12;
            14: o = 6'h28;
            15: o = 6'h2b;
            16: o = 6'h03;
            default: o = 6'h3f;
        endcase
        return {o, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom), f};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_full[k] = 1'b0;
            m_stall[k] = 0;
            for (int r = 0; r < 32; r++) avail[k][r] = 0;
        end
    endtask

    // One clock cycle: drive inputs, check at the falling edge against the model, advance the model
    task automatic step(input logic v, input logic [31:0] i, input logic f, input logic r, output bit a);
        bit hz, ov, iss, ir;
        logic [18:0] eb;
        in_valid = v;
        instr = i;
        flush = f;
        out_ready = r;
        @(negedge clk);
        a = 1'b0;
        if (ov_o[0] && r) dq.push_back(bus0.ctrl_dest);
        for (int k = 0; k < 2; k++) begin
            hz = m_full[k] && ref_hazard(k, m_instr[k]);
            ov = m_full[k] && !hz && !f;
            iss = ov && r;
            ir = !f && (!m_full[k] || iss);
            eb = ref_bundle(m_instr[k]);
            chk($sformatf("in_ready%0d@%0d", k, cyc), 32'(ir_o[k]), 32'(ir));
            chk($sformatf("out_valid%0d@%0d", k, cyc), 32'(ov_o[k]), 32'(ov));
            if (ov) chk($sformatf("bundle%0d@%0d", k, cyc), 32'(dut_b[k]), 32'(eb));
            chk($sformatf("stall%0d@%0d", k, cyc), 32'(st_o[k]), 32'(m_stall[k]));
            if (iss && eb[2] && eb[14:10] != 5'd0) avail[k][eb[14:10]] = cyc + 1 + lat[k];
            if (hz && !f) m_stall[k]++;
            m_full[k] = f ? 1'b0 : (v && ir) ? 1'b1 : iss ? 1'b0 : m_full[k];
            if (v && ir) m_instr[k] = i;
            if (k == 0) a = v && ir;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_bundle%0d", k), 32'(dut_b[k]), 32'd0);
            chk($sformatf("rst_out_valid%0d", k), 32'(ov_o[k]), 32'd0);
            chk($sformatf("rst_in_ready%0d", k), 32'(ir_o[k]), 32'd1);
            chk($sformatf("rst_stall%0d", k), 32'(st_o[k]), 32'd0);
        end

        step(1'b1, 32'h24410005, 1'b0, 1'b1, acc);
        in_valid = 1'b0;
        #1;
        chk("addi_valid", 32'(bus0.out_valid), 32'd1);
        chk("addi_aluop", 32'(bus0.ctrl_aluop), 32'd1);
        chk("addi_regwrite", 32'(bus0.ctrl_regwrite), 32'd1);
        chk("addi_dest", 32'(bus0.ctrl_dest), 32'd1);
        chk("addi_load", 32'(bus0.ctrl_load), 32'd0);
        step(1'b0, '0, 1'b0, 1'b1, acc);

        step(1'b1, i_type(6'h12, 5'd4, 5'd3, 16'd0), 1'b0, 1'b1, acc);
        step(1'b1, r_type(5'd3, 5'd6, 5'd5, 6'h20), 1'b0, 1'b1, acc);
        repeat (4) step(1'b0, '0, 1'b0, 1'b1, acc);
        chk("lat2_stall", 32'(st_o[0]), 32'd2);
        chk("lat1_stall", 32'(st_o[1]), 32'd1);

        step(1'b1, i_type(6'h12, 5'd4, 5'd0, 16'd0), 1'b0, 1'b1, acc);
        step(1'b1, r_type(5'd0, 5'd6, 5'd5, 6'h20), 1'b0, 1'b1, acc);
        repeat (3) step(1'b0, '0, 1'b0, 1'b1, acc);
        chk("r0_stall0", 32'(st_o[0]), 32'd2);
        chk("r0_stall1", 32'(st_o[1]), 32'd1);

        dq.delete();
        idx = 0;
        for (int j = 0; j < 10; j++) begin
            step(idx < 4, r_type(5'd1, 5'd2, 5'(10 + idx), 6'h20), 1'b0, j == 1 ? 1'b0 : 1'b1, acc);
            if (acc) idx++;
        end
        chk("stream_count", 32'(dq.size()), 32'd4);
        for (int j = 0; j < 4 && j < dq.size(); j++) chk($sformatf("stream_dest%0d", j), 32'(dq[j]), 32'(10 + j));

        dq.delete();
        step(1'b1, i_type(6'h12, 5'd4, 5'd7, 16'd0), 1'b0, 1'b1, acc);
        step(1'b1, r_type(5'd7, 5'd6, 5'd8, 6'h20), 1'b0, 1'b1, acc);
        step(1'b0, '0, 1'b0, 1'b1, acc);
        step(1'b0, '0, 1'b1, 1'b1, acc);
        flush = 1'b0;
        #1;
        chk("flush_drop", 32'(bus0.out_valid), 32'd0);
        step(1'b1, r_type(5'd7, 5'd6, 5'd9, 6'h20), 1'b0, 1'b1, acc);
        repeat (3) step(1'b0, '0, 1'b0, 1'b1, acc);
        chk("flush_issue_count", 32'(dq.size()), 32'd2);
        if (dq.size() == 2) begin
            chk("flush_first", 32'(dq[0]), 32'd7);
            chk("flush_second", 32'(dq[1]), 32'd9);
        end

        step(1'b1, {6'h3f, 26'h0}, 1'b0, 1'b1, acc);
        in_valid = 1'b0;
        #1;
        chk("ill_valid", 32'(bus0.out_valid), 32'd1);
        chk("ill_flag", 32'(bus0.ctrl_illegal), 32'd1);
        chk("ill_regwrite", 32'(bus0.ctrl_regwrite), 32'd0);
        chk("ill_mem_rw", 32'(bus0.ctrl_mem_rw), 32'd0);
        step(1'b0, '0, 1'b0, 1'b1, acc);

        step(1'b1, i_type(6'h12, 5'd4, 5'd3, 16'd0), 1'b0, 1'b1, acc);
        step(1'b1, r_type(5'd3, 5'd6, 5'd5, 6'h20), 1'b0, 1'b1, acc);
        step(1'b0, '0, 1'b0, 1'b1, acc);
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("midrst_bundle%0d", k), 32'(dut_b[k]), 32'd0);
            chk($sformatf("midrst_out_valid%0d", k), 32'(ov_o[k]), 32'd0);
            chk($sformatf("midrst_stall%0d", k), 32'(st_o[k]), 32'd0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc++;

        for (int n = 0; n < 300; n++)
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, acc);
        repeat (4) step(1'b0, '0, 1'b0, 1'b1, acc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
Registered, parametrised successor to the combinational control decoder. It accepts instructions over a valid/ready handshake, decodes them into the existing control bundle one cycle later, and holds the decoded instruction while a load-use hazard exists. Hazards are tracked by a per-register pending-load scoreboard with configurable load latency. It sits between fetch and the operand-read/execute stage and adds flush handling and illegal-opcode flagging.

Parameters:
REG_ADDR_W, 5, register index width; the scoreboard has 2^REG_ADDR_W entries.
LOAD_LAT, 2, cycles after a load issues before a dependent instruction may issue (1..7).
STALL_CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  instruction offered
in_ready  out  1  instruction accepted when in_valid && in_ready
instr  in  32  opcode[31:26], rs[25:21], rt[20:16], rd[15:11], func[5:0]
flush  in  1  discard held and incoming instruction
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts; issue = out_valid && out_ready
ctrl_aluop  out  3  ALU operation
ctrl_regwrite  out  1  writes register file
ctrl_dest  out  REG_ADDR_W  destination register
ctrl_jump  out  2  01 j/jal, 10 jr, 00 branch, 11 none
ctrl_branch  out  2  01 beq, 10 bne, 00 none
ctrl_mem_rw  out  2  10 read, 01 write, 00 none
ctrl_byte  out  1  byte access (lbu/sb)
ctrl_load, ctrl_store  out  1 each  load / store class
ctrl_illegal  out  1  undefined opcode; bundle otherwise a NOP
stall_cycles  out  STALL_CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset: decode register empty, all scoreboard counters 0, stall_cycles 0, every ctrl_* output 0, out_valid 0. in_ready is 1 after reset.
- Latency: an accepted instruction appears on the outputs the next cycle. Outputs hold stable while out_valid && !out_ready.
- in_ready = !flush && (!full || issue). This gives back-to-back throughput of one instruction per cycle.
- out_valid = full && !hazard && !flush.
- Decode uses the same opcode and func map as the existing decoder:
  - R-type opcode 0x03: func 0x08 jr, 0x21 lwn, 0x13 swn, any other func is an ALU op (aluop 0).
  - Jumps: 0x02 j; 0x07 jal (dest 31, aluop 1).
  - Immediates: 0x09 addi (aluop 1); 0x0c andi (aluop 3); 0x0e ori (aluop 4); 0x0f lui.
  - Branches: 0x05 beq; 0x04 bne (aluop 2).
  - Loads: 0x22 lbu; 0x12 lw.
  - Stores: 0x28 sb; 0x2b sw.
  - Any other opcode: ctrl_illegal=1, regwrite=0, mem_rw=00, jump=11.
- Destination register: rd for R-ALU; rt for I-type ALU ops, lui, lw, lbu and lwn; 31 for jal.
- Sources checked for hazards:
  - R-ALU, beq, bne, sb, sw: rs and rt.
  - lwn: rs and rd.
  - swn: rs, rd and rt.
  - addi, andi, ori, lw, lbu, jr: rs.
  - j, jal, lui, illegal: none.
- hazard = any used source register is nonzero and has scoreboard count > 0. Register 0 never hazards and is never marked.
- Scoreboard:
  - On issue of a load (lw, lbu, lwn) with dest != 0, count[dest] is set to LOAD_LAT.
  - Every cycle, each other nonzero count decrements by 1.
  - If set and decrement hit the same entry in the same cycle, set wins.
- stall_cycles increments each cycle with full && hazard && !flush, and saturates at all-ones.
- Flush:
  - Empties the decode register at the next edge and blocks acceptance that cycle.
  - Does not alter the scoreboard (issued loads still complete).
  - Flush while a hazard stall is in progress drops the stalled instruction.
- Reset asserted mid-operation clears everything immediately (asynchronous). Any in-flight instruction is lost.

Test Plan:
- addi r1,r2,5 (0x24410005), out_ready=1 -> next cycle out_valid=1, aluop=1, regwrite=1, dest=1, load=0.
- Issue lw r3,0(r4), then add r5,r3,r6 with LOAD_LAT=2 -> add held with out_valid=0 for 2 cycles, stall_cycles=2, then issues. Repeating with LOAD_LAT=1 gives 1 stall cycle.
- lw r0,0(r4) followed by add r5,r0,r6 -> no stall; stall_cycles stays 0.
- Stream 4 independent ALU ops with out_ready toggling 1,0,1,1 -> no instruction lost or duplicated, and outputs are stable while out_ready=0.
- Stalled add plus flush=1 for one cycle -> out_valid=0 next cycle, add never issues, and the pending load count continues to decrement.
- opcode 0x3f -> ctrl_illegal=1, regwrite=0, mem_rw=00. Separately, assert rst mid-stall -> all outputs and stall_cycles are 0 immediately.
